// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end.
// Owns the PC, issues word addresses to a synchronous-read instruction
// memory and fills the IF/ID register (instruction, pc_out, instr_valid).
// A one-entry skid buffer holds the word that returns on the first stalled
// edge, so the first unstalled edge delivers it with no bubble.
// Optional feature macro: FETCH_HALT_EN (halt on the word 24'hFFFFFF).
//
// Output semantics: instr_valid qualifies instruction/pc_out. There is no
// downstream ready; the consumer applies back-pressure with stall, which
// freezes IF/ID for that edge. redirect_valid overrides stall and flushes
// every in-flight and buffered word.
module fetch_stage #(
  parameter int                 ADDR_W  = 8,
  parameter int                 INSTR_W = 24,
  parameter logic [INSTR_W-1:0] NOP     = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               instr_valid,
  output logic               halted
);

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  localparam logic [INSTR_W-1:0] HALT_WORD = '1;

  logic [ADDR_W-1:0]  pc;
  logic               req_valid;
  logic [ADDR_W-1:0]  req_pc;
  logic               skid_valid;
  logic [INSTR_W-1:0] skid_data;
  logic [ADDR_W-1:0]  skid_pc;

  logic               load_valid;
  logic [INSTR_W-1:0] load_data;
  logic [ADDR_W-1:0]  load_pc;

  assign imem_addr = pc;

  // Select what IF/ID takes on a normal edge: skid first, then the word in flight.
  always_comb begin
    load_valid = 1'b0;
    load_data  = NOP;
    load_pc    = pc_out;
    if (skid_valid) begin
      load_valid = 1'b1;
      load_data  = skid_data;
      load_pc    = skid_pc;
    end else if (req_valid) begin
      load_valid = 1'b1;
      load_data  = imem_data;
      load_pc    = req_pc;
    end
  end

  // PC, request tracking, skid buffer, IF/ID and halt flag; redirect > stall > normal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      req_valid   <= 1'b0;
      req_pc      <= '0;
      skid_valid  <= 1'b0;
      skid_data   <= NOP;
      skid_pc     <= '0;
      instruction <= NOP;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (redirect_valid) begin
      pc          <= redirect_pc;
      req_valid   <= 1'b0;
      skid_valid  <= 1'b0;
      instruction <= NOP;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (stall) begin
      // The word returning on this edge would be lost; park it once.
      if (req_valid && !skid_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= imem_data;
        skid_pc    <= req_pc;
      end
      // Anything read while stalled is dropped; pc is reissued afterwards.
      req_valid <= 1'b0;
    end else if (halted) begin
      // Halted: drain to bubbles, issue nothing, pc holds.
      instruction <= NOP;
      instr_valid <= 1'b0;
      req_valid   <= 1'b0;
      skid_valid  <= 1'b0;
    end else begin
      instruction <= load_valid ? load_data : NOP;
      instr_valid <= load_valid;
      pc_out      <= load_pc;
      skid_valid  <= 1'b0;
      req_valid   <= 1'b1;
      req_pc      <= pc;
      pc          <= pc + ADDR_W'(1);
      if (HALT_EN && load_valid && (load_data == HALT_WORD)) begin
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a synchronous-read
// instruction memory model, mem[i] = i + 1.
module tb_fetch_stage;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 24;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               stall = 1'b0;
  logic               redirect_valid = 1'b0;
  logic [ADDR_W-1:0]  redirect_pc = '0;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data = '0;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0]  pc_out;
  logic               instr_valid;
  logic               halted;

  fetch_stage #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .NOP(24'h000000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .instruction    (instruction),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .halted         (halted)
  );

  // Synchronous-read instruction memory.
  logic [INSTR_W-1:0] mem [256];
  always @(posedge clk) imem_data <= mem[imem_addr];

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [ADDR_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_valid(input string tag, input logic [ADDR_W-1:0] p,
                           input logic [INSTR_W-1:0] d);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
    chk({tag, ".pc"},    32'(pc_out),      32'(p));
    chk({tag, ".instr"}, 32'(instruction), 32'(d));
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
    chk({tag, ".instr"}, 32'(instruction), 32'd0);
  endtask

  task automatic do_redirect(input logic [ADDR_W-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = INSTR_W'(i + 1);

    // Reset state.
    step();
    step();
    chk("rst.addr",  32'(imem_addr),   32'd0);
    chk("rst.instr", 32'(instruction), 32'd0);
    chk("rst.pc",    32'(pc_out),      32'd0);
    chk("rst.valid", 32'(instr_valid), 32'd0);
    chk("rst.halt",  32'(halted),      32'd0);

    // Release reset away from the edge.
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("e1.valid", 32'(instr_valid), 32'd0);
    chk("e1.addr",  32'(imem_addr),   32'd1);
    step();
    chk_valid("e2", 8'h00, 24'd1);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_valid("seq", ADDR_W'(k), INSTR_W'(k + 1));
    end

    // Stall for three edges while pc_out = 5.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_valid("stall", 8'h05, 24'd6);
    end
    stall = 1'b0;
    step();
    chk_valid("unstall0", 8'h06, 24'd7);
    step();
    chk_valid("unstall1", 8'h07, 24'd8);

    // Redirect to 0, run up to pc_out = 3, then redirect to 0x40.
    do_redirect(8'h00);
    chk_bubble("rd0.b0");
    step();
    chk_bubble("rd0.b1");
    for (int k = 0; k <= 3; k++) begin
      step();
      chk_valid("rd0.seq", ADDR_W'(k), INSTR_W'(k + 1));
    end
    do_redirect(8'h40);
    chk_bubble("rd40.b0");
    step();
    chk_bubble("rd40.b1");
    step();
    chk_valid("rd40.t0", 8'h40, 24'h41);
    step();
    chk_valid("rd40.t1", 8'h41, 24'h42);

    // Redirect to 0x10 in the 2nd cycle of a 4-cycle stall.
    stall = 1'b1;
    step();
    chk_valid("srd.s1", 8'h41, 24'h42);
    do_redirect(8'h10);
    chk_bubble("srd.s2");
    step();
    chk_bubble("srd.s3");
    step();
    chk_bubble("srd.s4");
    stall = 1'b0;
    step();
    chk_bubble("srd.b");
    step();
    chk_valid("srd.t0", 8'h10, 24'h11);

    // PC wrap: 0xFE, 0xFF, 0x00, 0x01 with no bubble.
    do_redirect(8'hFE);
    step();
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    while (exp_q.size() > 0) begin
      logic [ADDR_W-1:0] e;
      e = exp_q.pop_front();
      step();
      chk_valid("wrap", e, INSTR_W'({1'b0, e} + 9'd1));
    end

    // Halt word at address 3.
    mem[3] = 24'hFFFFFF;
    do_redirect(8'h02);
    chk("halt.clr", 32'(halted), 32'd0);
    step();
    step();
    chk_valid("halt.p2", 8'h02, 24'd3);
    step();
    chk_valid("halt.p3", 8'h03, 24'hFFFFFF);
    chk("halt.set", 32'(halted), 32'(HALT_EN));
    step();
    if (HALT_EN) begin
      chk_bubble("halt.h0");
      chk("halt.addr0", 32'(imem_addr), 32'd5);
      for (int k = 0; k < 4; k++) step();
      chk_bubble("halt.h1");
      chk("halt.addr1", 32'(imem_addr), 32'd5);
      chk("halt.stay",  32'(halted),    32'd1);
    end else begin
      chk_valid("nohalt.p4", 8'h04, 24'd5);
      chk("nohalt.flag", 32'(halted), 32'd0);
    end
    do_redirect(8'h00);
    chk("restart.halt", 32'(halted), 32'd0);
    chk_bubble("restart.b0");
    step();
    step();
    chk_valid("restart.t0", 8'h00, 24'd1);

    // Mid-operation reset clears everything at once.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(instr_valid), 32'd0);
    chk("arst.addr",  32'(imem_addr),   32'd0);
    chk("arst.pc",    32'(pc_out),      32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog keeps the run bounded.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
